// File: rtl/fp_hp_pkg.sv
// Shared half-precision constants, operand layout and arbiter FSM state encoding.
package fp_hp_pkg;

  localparam int unsigned EXP_W = 5;
  localparam int unsigned MAN_W = 10;
  localparam int unsigned W     = 1 + EXP_W + MAN_W;
  localparam int unsigned BIAS  = 15;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exponent;
    logic [MAN_W-1:0] mantissa;
  } fp16_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RESP
  } state_t;

endpackage

// File: rtl/FMul_HalfPrecision.sv
// Combinational half-precision multiplier: implicit-one significand product, truncating
// normalisation, and exponent overflow/underflow flags.
module FMul_HalfPrecision #(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10
) (
  input  logic             sign1,
  input  logic [EXP_W-1:0] exp1,
  input  logic [MAN_W-1:0] man1,
  input  logic             sign2,
  input  logic [EXP_W-1:0] exp2,
  input  logic [MAN_W-1:0] man2,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic [MAN_W-1:0] out_man,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned PW   = 2 * (MAN_W + 1);
  localparam int unsigned EW   = EXP_W + 2;
  localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int unsigned EMAX = (1 << EXP_W) - 1;

  logic [PW-1:0] prod;
  logic [PW-1:0] prod_n;
  logic          norm;
  logic [EW-1:0] exp_biased;
  logic          unused_bits;

  assign prod   = PW'({1'b1, man1}) * PW'({1'b1, man2});
  assign norm   = prod[PW-1];
  assign prod_n = norm ? prod : (prod << 1);

  // Exponent kept with the bias still added so the range checks stay unsigned.
  assign exp_biased = EW'(exp1) + EW'(exp2) + EW'(norm);

  assign out_sign    = sign1 ^ sign2;
  assign out_man     = prod_n[PW-2 -: MAN_W];
  assign out_exp     = EXP_W'(exp_biased - EW'(BIAS));
  assign overflow    = (exp_biased >= EW'(BIAS + EMAX));
  assign underflow   = (exp_biased <= EW'(BIAS));
  assign unused_bits = ^prod_n[PW-MAN_W-2:0];

endmodule

// File: rtl/fmul_hp_arbiter.sv
// Round-robin arbiter sharing one half-precision multiplier between two requesters,
// returning a tagged, registered result on a single response channel.
module fmul_hp_arbiter #(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [EXP_W+MAN_W:0]   req0_a,
  input  logic [EXP_W+MAN_W:0]   req0_b,
  input  logic [EXP_W+MAN_W:0]   req1_a,
  input  logic [EXP_W+MAN_W:0]   req1_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic [EXP_W+MAN_W:0]   rsp_result,
  output logic                   rsp_overflow,
  output logic                   rsp_underflow,
  output logic                   busy
);

  import fp_hp_pkg::*;

  localparam int unsigned OW = 1 + EXP_W + MAN_W;

  state_t          state_q, state_d;
  logic            prio_q, id_q, grant;
  logic            load, capture, drain;
  logic [OW-1:0]   a_q, b_q, res_q;
  logic            ovf_q, unf_q;
  logic            p_sign, p_ovf, p_unf;
  logic [EXP_W-1:0] p_exp;
  logic [MAN_W-1:0] p_man;

  // Next state, grant and register enables.
  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    grant     = 1'b0;
    load      = 1'b0;
    capture   = 1'b0;
    drain     = 1'b0;
    case (state_q)
      IDLE: begin
        grant = (&req_valid) ? prio_q : req_valid[1];
        if (rst_n && (|req_valid)) begin
          req_ready = grant ? 2'b10 : 2'b01;
          load      = 1'b1;
          state_d   = CALC;
        end
      end
      CALC: begin
        capture = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          drain   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      id_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        id_q <= grant;
        a_q  <= grant ? req1_a : req0_a;
        b_q  <= grant ? req1_b : req0_b;
      end
      if (capture) begin
        res_q <= {p_sign, p_exp, p_man};
        ovf_q <= p_ovf;
        unf_q <= p_unf;
      end
      // Served requester drops to lowest priority.
      if (drain) prio_q <= ~id_q;
    end
  end

  FMul_HalfPrecision #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_fmul (
    .sign1    (a_q[OW-1]),
    .exp1     (a_q[OW-2 -: EXP_W]),
    .man1     (a_q[MAN_W-1:0]),
    .sign2    (b_q[OW-1]),
    .exp2     (b_q[OW-2 -: EXP_W]),
    .man2     (b_q[MAN_W-1:0]),
    .out_sign (p_sign),
    .out_exp  (p_exp),
    .out_man  (p_man),
    .overflow (p_ovf),
    .underflow(p_unf)
  );

  assign rsp_valid     = (state_q == RESP);
  assign busy          = (state_q != IDLE);
  assign rsp_id        = id_q;
  assign rsp_result    = res_q;
  assign rsp_overflow  = ovf_q;
  assign rsp_underflow = unf_q;

endmodule

// File: tb/tb_fmul_hp_arbiter.sv
// Scoreboard bench for fmul_hp_arbiter: real-valued reference multiply, grant order,
// latency, back-pressure, flags and mid-operation reset.
module tb_fmul_hp_arbiter;
  import fp_hp_pkg::*;

  typedef struct packed {
    logic  id;
    logic  ovf;
    logic  unf;
    fp16_t res;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [15:0] rsp_result;
  logic        rsp_overflow, rsp_underflow, busy;

  exp_t exp_q[$];
  int   grant_log[$];
  int   acc_cnt = 0;
  int   rsp_cnt = 0;
  int   total   = 0;
  int   bad     = 0;

  always #5 clk = ~clk;

  fmul_hp_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_overflow (rsp_overflow),
    .rsp_underflow(rsp_underflow),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Reference: significands multiplied as reals, truncated to 10 fraction bits.
  function automatic exp_t model(input logic id, input logic [15:0] a, input logic [15:0] b);
    fp16_t fa, fb;
    exp_t  r;
    real   p;
    int    e;
    fa = a;
    fb = b;
    p  = real'(1024 + int'(fa.mantissa)) * real'(1024 + int'(fb.mantissa)) / 1048576.0;
    e  = int'(fa.exponent) + int'(fb.exponent) - int'(BIAS);
    if (p >= 2.0) begin
      p = p / 2.0;
      e++;
    end
    r.id           = id;
    r.res.sign     = fa.sign ^ fb.sign;
    r.res.exponent = 5'(e);
    r.res.mantissa = 10'($rtoi((p - 1.0) * 1024.0));
    r.ovf          = (e >= 31);
    r.unf          = (e <= 0);
    return r;
  endfunction

  // Handshakes are sampled on the falling edge; they complete on the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (req_valid[0] && req_ready[0]) begin
        exp_q.push_back(model(1'b0, req0_a, req0_b));
        grant_log.push_back(0);
        acc_cnt++;
      end
      if (req_valid[1] && req_ready[1]) begin
        exp_q.push_back(model(1'b1, req1_a, req1_b));
        grant_log.push_back(1);
        acc_cnt++;
      end
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(e.id));
          check("rsp_result", 32'(rsp_result), 32'(e.res));
          check("rsp_overflow", 32'(rsp_overflow), 32'(e.ovf));
          check("rsp_underflow", 32'(rsp_underflow), 32'(e.unf));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b);
    int start;
    start = acc_cnt;
    if (id == 0) begin
      req0_a = a;
      req0_b = b;
    end else begin
      req1_a = a;
      req1_b = b;
    end
    req_valid[id] = 1'b1;
    for (int i = 0; i < 50 && acc_cnt == start; i++) tick();
    check("accepted", 32'(acc_cnt - start), 32'd1);
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && (busy || rsp_valid); i++) tick();
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Holds the response for two cycles to check the flags directly, then drains it.
  task automatic run_flags(input int id, input logic [15:0] a, input logic [15:0] b,
                           input logic want_ovf, input logic want_unf);
    rsp_ready = 1'b0;
    issue(id, a, b);
    tick();
    tick();
    check("flag_valid", 32'(rsp_valid), 32'd1);
    check("flag_ovf", 32'(rsp_overflow), 32'(want_ovf));
    check("flag_unf", 32'(rsp_underflow), 32'(want_unf));
    rsp_ready = 1'b1;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req0_a    = 16'h3E00;
    req0_b    = 16'h4000;
    req1_a    = 16'h3C00;
    req1_b    = 16'h3C00;
    rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_result", 32'(rsp_result), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_flags", 32'({rsp_overflow, rsp_underflow}), 32'd0);

    // Contention straight out of reset.
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("first_grant", 32'(req_ready), 32'd1);
    for (int i = 0; i < 60 && grant_log.size() < 4; i++) tick();
    req_valid = 2'b00;
    check("grant_count", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check("grant_order", 32'(grant_log[i]), 32'(i % 2));
    wait_idle();
    check("contention_rsp_cnt", 32'(rsp_cnt), 32'd4);

    // Single multiply, latency and back-pressure.
    rsp_ready = 1'b0;
    issue(0, 16'h3E00, 16'h4000);
    check("lat_busy", 32'(busy), 32'd1);
    check("lat_no_rsp_yet", 32'(rsp_valid), 32'd0);
    tick();
    tick();
    check("lat_rsp_valid", 32'(rsp_valid), 32'd1);
    check("single_id", 32'(rsp_id), 32'd0);
    check("single_result", 32'(rsp_result), 32'h4200);
    check("single_flags", 32'({rsp_overflow, rsp_underflow}), 32'd0);
    req0_a    = 16'h4000;
    req0_b    = 16'h4000;
    req1_a    = 16'hC000;
    req1_b    = 16'h3E00;
    req_valid = 2'b11;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_result", 32'(rsp_result), 32'h4200);
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_drained", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("rr_after_drain", 32'(req_ready), 32'd2);
    tick();
    req_valid = 2'b00;
    wait_idle();

    run_flags(0, 16'h7800, 16'h7800, 1'b1, 1'b0);
    run_flags(1, 16'h0400, 16'h0400, 1'b0, 1'b1);
    run_flags(0, 16'hBC00, 16'h3C00, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      rsp_ready = 1'b1;
      issue(int'($urandom_range(1, 0)), 16'($urandom), 16'($urandom));
      wait_idle();
    end

    // Leave prio at 1, then reset during CALC.
    issue(0, 16'h3C00, 16'h3C00);
    wait_idle();
    issue(0, 16'h4000, 16'h4000);
    check("mid_in_calc", 32'(busy && !rsp_valid), 32'd1);
    r     = rsp_cnt;
    rst_n = 1'b0;
    exp_q.delete();
    #2;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) tick();
    check("mid_no_rsp", 32'(rsp_cnt - r), 32'd0);
    check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    req0_a    = 16'h3E00;
    req0_b    = 16'h3E00;
    req1_a    = 16'h4200;
    req1_b    = 16'h3800;
    req_valid = 2'b11;
    @(negedge clk);
    check("mid_prio_reset", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b00;
    wait_idle();
    check("mid_next_done", 32'(rsp_cnt - r), 32'd1);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
